key_entry: RTL and testbench

Debounced key-entry accumulator sitting directly downstream of the keypad decoder. It samples the decoder's 4-bit key code (15 = no key), accepts a key only after it has been stable for a set number of clocks, and generates one event per press. Each event edits a 4-digit BCD entry buffer (digit insert, backspace, clear). On the enter key, the buffer is committed as a value for the rest of the design.

---
 rtl/key_entry.sv | 145 ++++++++++++++
 tb/tb_key_entry.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_entry.sv
// key_entry: debounced key-entry accumulator for the keypad decoder output.
// A code must be seen unchanged for STABLE_CYCLES samples before it counts.
// Each accepted press produces one event, and each event edits a 4-digit BCD
// entry buffer. Pressing enter commits the buffer to `value`.
module key_entry #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic [3:0]  num,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic [2:0]  count,
  output logic [15:0] value,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] NO_KEY    = 4'd15;
  localparam logic [3:0] KEY_BKSP  = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd13;
  localparam logic [3:0] KEY_CLEAR = 4'd14;
  localparam logic [3:0] MAX_DIGIT = 4'd9;
  localparam logic [2:0] STABLE_MAX = 3'(STABLE_CYCLES);
  localparam logic [2:0] FULL_COUNT = 3'd4;

  typedef enum logic {
    ARMED,
    WAIT_REL
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  last;
  logic [2:0]  stab_cnt;
  logic        stable;
  logic        fire;

  logic [15:0] digits_nxt;
  logic [2:0]  count_nxt;
  logic [15:0] value_nxt;
  logic        done_nxt;
  logic        err_nxt;

  // Stability tracker: restart the run length whenever the sampled code changes.
  always_ff @(posedge clk_1) begin
    // NOTE: non-blocking assignments for every register so all flops update
    // together from pre-edge values, independent of statement order.
    if (rst) begin
      last     <= NO_KEY;
      stab_cnt <= 3'd0;
    end else if (num != last) begin
      last     <= num;
      stab_cnt <= 3'd1;
    end else if (stab_cnt != STABLE_MAX) begin
      stab_cnt <= stab_cnt + 3'd1;
    end
  end

  assign stable = (stab_cnt == STABLE_MAX);

  // FSM state register; resets into WAIT_REL so a key held through reset is ignored.
  always_ff @(posedge clk_1) begin
    if (rst) state <= WAIT_REL;
    else     state <= state_nxt;
  end

  // Next state: a stable key arms the release wait, and a stable release re-arms.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    state_nxt = state;
    unique case (state)
      ARMED:    if (stable && last != NO_KEY) state_nxt = WAIT_REL;
      WAIT_REL: if (stable && last == NO_KEY) state_nxt = ARMED;
      default:  state_nxt = WAIT_REL;
    endcase
  end

  // Output decode: detect the firing edge and work out the buffer edit it causes.
  always_comb begin
    fire       = (state == ARMED) && stable && (last != NO_KEY);
    digits_nxt = digits;
    count_nxt  = count;
    value_nxt  = value;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    if (fire) begin
      if (last <= MAX_DIGIT) begin
        if (count < FULL_COUNT) begin
          digits_nxt = {digits[11:0], last};
          count_nxt  = count + 3'd1;
        end else begin
          err_nxt = 1'b1;
        end
      end else begin
        case (last)
          KEY_BKSP: begin
            // Backspace on an empty buffer is a silent no-op.
            if (count != 3'd0) begin
              digits_nxt = {4'h0, digits[15:4]};
              count_nxt  = count - 3'd1;
            end
          end
          KEY_CLEAR: begin
            digits_nxt = 16'h0000;
            count_nxt  = 3'd0;
          end
          KEY_ENTER: begin
            if (count != 3'd0) begin
              value_nxt  = digits;
              done_nxt   = 1'b1;
              digits_nxt = 16'h0000;
              count_nxt  = 3'd0;
            end else begin
              err_nxt = 1'b1;
            end
          end
          default: ;  // B and C are reported but leave the buffer untouched
        endcase
      end
    end
  end

  // Registered outputs: pulses last one cycle, and the buffer moves only on events.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= NO_KEY;
      digits    <= 16'h0000;
      count     <= 3'd0;
      value     <= 16'h0000;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      key_valid <= fire;
      if (fire) key_code <= last;
      digits    <= digits_nxt;
      count     <= count_nxt;
      value     <= value_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_key_entry.sv
// tb_key_entry: scoreboard bench for key_entry. Each press pushes the event
// expected from a small behavioural model. A monitor pops an entry on every
// key_valid pulse and compares the DUT outputs and the firing cycle with it.
module tb_key_entry;

  localparam int S = 4;

  logic        clk_1 = 1'b0;
  logic        rst   = 1'b1;
  logic [3:0]  num   = 4'd15;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [2:0]  count;
  logic [15:0] value;
  logic        done;
  logic        err;

  key_entry #(.STABLE_CYCLES(S)) dut (
    .clk_1     (clk_1),
    .rst       (rst),
    .num       (num),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digits    (digits),
    .count     (count),
    .value     (value),
    .done      (done),
    .err       (err)
  );

  always #5 clk_1 = ~clk_1;

  int cycle_cnt = 0;
  always @(posedge clk_1) cycle_cnt = cycle_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle_cnt);
    end
  endtask

  typedef struct {
    logic [3:0]  code;
    logic [15:0] digits;
    logic [2:0]  count;
    logic [15:0] value;
    logic        done;
    logic        err;
    int          cycle;
  } ev_t;

  ev_t sb[$];

  // Behavioural model of the entry buffer.
  logic [15:0] m_digits = 16'h0;
  int          m_count  = 0;
  logic [15:0] m_value  = 16'h0;

  task automatic model_reset();
    m_digits = 16'h0;
    m_count  = 0;
    m_value  = 16'h0;
  endtask

  // Called at the negedge on which `code` is first driven.
  task automatic expect_event(input logic [3:0] code);
    ev_t e;
    e.done = 1'b0;
    e.err  = 1'b0;
    if (code <= 4'd9) begin
      if (m_count < 4) begin
        m_digits = {m_digits[11:0], code};
        m_count++;
      end else e.err = 1'b1;
    end else if (code == 4'd10) begin
      if (m_count > 0) begin
        m_digits = m_digits >> 4;
        m_count--;
      end
    end else if (code == 4'd14) begin
      m_digits = 16'h0;
      m_count  = 0;
    end else if (code == 4'd13) begin
      if (m_count > 0) begin
        m_value  = m_digits;
        e.done   = 1'b1;
        m_digits = 16'h0;
        m_count  = 0;
      end else e.err = 1'b1;
    end
    e.code   = code;
    e.digits = m_digits;
    e.count  = 3'(m_count);
    e.value  = m_value;
    e.cycle  = cycle_cnt + 1 + S;
    sb.push_back(e);
  endtask

  task automatic hold(input logic [3:0] code, input int n);
    num = code;
    repeat (n) @(negedge clk_1);
  endtask

  task automatic press(input logic [3:0] code);
    expect_event(code);
    hold(code, S);
    hold(4'd15, S);
  endtask

  // Monitor: compare every event with the scoreboard, sampling on the falling edge.
  always @(negedge clk_1) begin
    if (!rst) begin
      if (key_valid) begin
        if (sb.size() == 0) begin
          check("spurious_key_valid", 32'(key_valid), 32'd0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          check("event_cycle", 32'(cycle_cnt), 32'(e.cycle));
          check("key_code",    32'(key_code),  32'(e.code));
          check("digits",      32'(digits),    32'(e.digits));
          check("count",       32'(count),     32'(e.count));
          check("value",       32'(value),     32'(e.value));
          check("done",        32'(done),      32'(e.done));
          check("err",         32'(err),       32'(e.err));
        end
      end else if (done || err) begin
        check("orphan_pulse", {30'd0, done, err}, 32'd0);
      end
    end
  end

  initial begin
    // Reset with no key, then check every reset value.
    repeat (2) @(negedge clk_1);
    rst = 1'b0;
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_code",  32'(key_code),  32'd15);
    check("rst_digits",    32'(digits),    32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_value",     32'(value),     32'd0);
    check("rst_done_err",  {30'd0, done, err}, 32'd0);
    hold(4'd15, S);

    // First press after reset.
    press(4'd7);

    // Clear, then overflow the buffer on the fifth digit.
    press(4'd14);
    for (int d = 1; d <= 5; d++) press(4'(d));

    // Backspace down to empty, then once more with no error.
    press(4'd14);
    for (int d = 1; d <= 3; d++) press(4'(d));
    for (int i = 0; i < 4; i++) press(4'd10);

    // B and C change nothing; enter commits; enter when empty is an error.
    press(4'd9);
    press(4'd8);
    press(4'd11);
    press(4'd12);
    press(4'd13);
    press(4'd13);

    // Switching to a different key without a release fires nothing extra.
    expect_event(4'd3);
    hold(4'd3, S);
    hold(4'd4, 2 * S);
    hold(4'd15, S);

    // Glitch rejection: toggling and a too-short hold produce no event.
    for (int i = 0; i < 20; i++) hold((i % 2 == 0) ? 4'd5 : 4'd15, 1);
    hold(4'd5, S - 1);
    hold(4'd15, S);
    press(4'd5);

    // Reset while a key is held: the buffer and value are lost, and the key is ignored.
    check("sb_drained_before_rst", 32'(sb.size()), 32'd0);
    num = 4'd6;
    rst = 1'b1;
    repeat (2) @(negedge clk_1);
    rst = 1'b0;
    model_reset();
    check("rst2_value",  32'(value),  32'd0);
    check("rst2_digits", 32'(digits), 32'd0);
    check("rst2_count",  32'(count),  32'd0);
    hold(4'd6, 10);
    hold(4'd15, S);
    press(4'd6);
    check("final_digits", 32'(digits), 32'h0006);

    repeat (4) @(negedge clk_1);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
